axi4_stream_i2s_tx: RTL
=======================

AXI4_STREAM_I2S_TX -- requirements
Module: axi4_stream_i2s_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of S_AXIS_TDATA.
REQ-002 Parameter SAMPLE_WIDTH, default 16: MSBs of each beat transmitted; SAMPLE_WIDTH <= 32.
REQ-003 Parameter BCLK_DIV, default 4: ACLK cycles per BCLK half-period; BCLK_DIV >= 2.
REQ-004 ACLK  in  1: the block's single clock; all logic is on its rising edge.
REQ-005 ARESETN  in  1: reset, asynchronous assert and active-low.
REQ-006 S_AXIS_TVALID  in  1: upstream beat valid.
REQ-007 S_AXIS_TREADY  out  1: block accepts a beat this cycle.
REQ-008 S_AXIS_TLAST  in  1: 0 = left sample, 1 = right sample.
REQ-009 S_AXIS_TDATA  in  DATA_WIDTH: sample, left-justified.
REQ-010 I2S_BCLK  out  1: serial bit clock, ACLK/(2*BCLK_DIV).
REQ-011 I2S_LRCLK  out  1: word select, 0 = left, 1 = right.
REQ-012 I2S_SDATA  out  1: serial data, MSB first.
REQ-013 underrun  out  1: one-ACLK pulse when a frame starts without a complete pair.
REQ-014 sync_err  out  1: one-ACLK pulse when a beat's TLAST breaks L/R alternation.

Function
REQ-015 Divider counter 0..BCLK_DIV-1 SHALL toggle I2S_BCLK at terminal count; a 1->0 toggle is a "fall event".
REQ-016 Slot counter 0..63 SHALL advance on each fall event, wrapping 63->0; I2S_LRCLK SHALL equal (slot >= 32), updated on the fall event.
REQ-017 Frame word SHALL be 64 bits: {left[SAMPLE_WIDTH] zero-padded to 32, right[SAMPLE_WIDTH] zero-padded to 32}; left sample = TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH].
REQ-018 On fall event entering slot s, I2S_SDATA SHALL present frame bit (63-(s-1)); slot 0 presents the LSB of the previous frame (standard one-BCLK I2S delay).
REQ-019 Staging buffer SHALL hold one left and one right sample plus state EXPECT_L / EXPECT_R and flag pair_full.
REQ-020 S_AXIS_TREADY SHALL be registered and equal !pair_full.
REQ-021 EXPECT_L, accepted beat TLAST=0: store left, go EXPECT_R.
REQ-022 EXPECT_L, accepted beat TLAST=1: discard beat, pulse sync_err, stay EXPECT_L.
REQ-023 EXPECT_R, accepted beat TLAST=1: store right, set pair_full, go EXPECT_L.
REQ-024 EXPECT_R, accepted beat TLAST=0: overwrite left, pulse sync_err, stay EXPECT_R.
REQ-025 Frame load occurs on the fall event entering slot 0: if pair_full, shift register loads the pair and pair_full clears in the same cycle.
REQ-026 Frame load without pair_full SHALL load all zeros, pulse underrun, and keep any stored left sample and EXPECT_R state.
REQ-027 A beat handshaking in the same cycle as frame load SHALL be applied after the load decision (it completes the pair for the next frame).
REQ-028 Latency: pair completed before a frame load is transmitted in that frame; TREADY re-asserts one cycle after load.

Reset
REQ-029 ARESETN low SHALL asynchronously force: I2S_BCLK=0, I2S_LRCLK=1, I2S_SDATA=0, S_AXIS_TREADY=0, underrun=0, sync_err=0, slot=63, divider=0, EXPECT_L, pair_full=0, shift register=0.
REQ-030 S_AXIS_TREADY SHALL rise on the first ACLK edge after reset release; first frame load occurs at the first fall event.
REQ-031 Reset mid-frame SHALL abort the frame; staged samples are lost.

Structure
REQ-032 Shared package axi4_stream_audio_pkg SHALL hold I2S_SLOT_BITS=32, I2S_FRAME_BITS=64 and the EXPECT_L/EXPECT_R state type.
REQ-033 Divider and slot counter SHALL be sub-module i2s_clock_gen, outputting I2S_BCLK, I2S_LRCLK, fall-event strobe and slot index.

Verification
REQ-034 Beats L=0xA5A5_0000 (TLAST 0), R=0x1234_0000 (TLAST 1), defaults -> frame bits 1..16 = 0xA5A5, bits 33..48 = 0x1234, rest 0; no pulses.
REQ-035 No input after reset -> first frame all zero, underrun pulses once per frame (every 512 ACLK at BCLK_DIV=4).
REQ-036 Beats L, L, R -> one sync_err pulse; second L transmitted with R.
REQ-037 TLAST=1 as first beat -> dropped, sync_err pulse, next L/R pair transmitted intact.
REQ-038 Continuous TVALID -> TREADY low after each pair, high one cycle after each frame load; exactly one pair accepted per 512 ACLK; no underrun.
REQ-039 ARESETN low during slot 40 -> all outputs at reset values same cycle, no ACLK edge required; post-release frame starts with LRCLK falling.

Source files
------------

// File: rtl/axi4_stream_audio_pkg.sv
// Constants and the staging-state type shared by the AXI4-Stream audio blocks.
package axi4_stream_audio_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_IDX_W = $clog2(I2S_FRAME_BITS);

    typedef enum logic {
        EXPECT_L = 1'b0,
        EXPECT_R = 1'b1
    } stage_state_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// BCLK divider and 64-slot frame counter; fall_o strobes on the ACLK edge where BCLK goes 1->0.
module i2s_clock_gen
    import axi4_stream_audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    output logic                      bclk_o,
    output logic                      lrclk_o,
    output logic                      fall_o,
    output logic [I2S_SLOT_IDX_W-1:0] slot_o
);

    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [DIV_W-1:0]          div_q, div_d;
    logic                      bclk_q, bclk_d;
    logic                      lrclk_q, lrclk_d;
    logic [I2S_SLOT_IDX_W-1:0] slot_q, slot_d;
    logic                      tc;
    logic                      fall;

    always_comb begin
        tc      = (div_q == DIV_W'(BCLK_DIV - 1));
        div_d   = tc ? '0 : div_q + 1'b1;
        bclk_d  = tc ? ~bclk_q : bclk_q;
        fall    = tc && bclk_q;
        slot_d  = fall ? slot_q + 1'b1 : slot_q;
        // Right channel occupies the upper half of the frame.
        lrclk_d = fall ? slot_d[I2S_SLOT_IDX_W-1] : lrclk_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b1;
            slot_q  <= '1;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            slot_q  <= slot_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lrclk_q;
    assign fall_o  = fall;
    assign slot_o  = slot_q;

endmodule

// File: rtl/axi4_stream_i2s_tx.sv
// AXI4-Stream to I2S transmitter: stages one L/R pair and serialises it MSB first with one-BCLK delay.
//   state    | meaning
//   EXPECT_L | next accepted beat should be a left sample (TLAST=0)
//   EXPECT_R | left sample held, next accepted beat should be right (TLAST=1)
module axi4_stream_i2s_tx
    import axi4_stream_audio_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_DIV     = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_TLAST,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    output logic                  I2S_BCLK,
    output logic                  I2S_LRCLK,
    output logic                  I2S_SDATA,
    output logic                  underrun,
    output logic                  sync_err
);

    logic                      fall;
    logic [I2S_SLOT_IDX_W-1:0] slot;

    i2s_clock_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_clock_gen (
        .clk_i  (ACLK),
        .rst_n_i(ARESETN),
        .bclk_o (I2S_BCLK),
        .lrclk_o(I2S_LRCLK),
        .fall_o (fall),
        .slot_o (slot)
    );

    logic [SAMPLE_WIDTH-1:0]   left_q, left_d;
    logic [SAMPLE_WIDTH-1:0]   right_q, right_d;
    logic [SAMPLE_WIDTH-1:0]   sample;
    stage_state_t              state_q, state_d;
    logic                      pair_full_q, pair_full_d;
    logic                      tready_q, tready_d;
    logic                      sdata_q, sdata_d;
    logic                      underrun_q, underrun_d;
    logic                      sync_err_q, sync_err_d;
    logic [I2S_FRAME_BITS-1:0] shift_q, shift_d;
    logic [I2S_FRAME_BITS-1:0] pair_word;
    logic                      frame_load;
    logic                      beat;
    logic                      unused_tdata;

    assign sample       = S_AXIS_TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign unused_tdata = ^S_AXIS_TDATA;
    assign frame_load   = fall && (slot == I2S_SLOT_IDX_W'(I2S_FRAME_BITS - 1));
    assign beat         = S_AXIS_TVALID && tready_q;
    assign pair_word    = {I2S_SLOT_BITS'(left_q)  << (I2S_SLOT_BITS - SAMPLE_WIDTH),
                           I2S_SLOT_BITS'(right_q) << (I2S_SLOT_BITS - SAMPLE_WIDTH)};

    always_comb begin
        left_d      = left_q;
        right_d     = right_q;
        state_d     = state_q;
        pair_full_d = pair_full_q;
        sdata_d     = sdata_q;
        shift_d     = shift_q;
        underrun_d  = 1'b0;
        sync_err_d  = 1'b0;

        // MSB is always on the wire; entering slot 0 emits the old frame's LSB while loading.
        if (fall) begin
            sdata_d = shift_q[I2S_FRAME_BITS-1];
            shift_d = shift_q << 1;
        end

        if (frame_load) begin
            if (pair_full_q) begin
                shift_d     = pair_word;
                pair_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Beat is applied after the load decision so it feeds the following frame.
        if (beat) begin
            case (state_q)
                EXPECT_L: begin
                    if (!S_AXIS_TLAST) begin
                        left_d  = sample;
                        state_d = EXPECT_R;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                EXPECT_R: begin
                    if (S_AXIS_TLAST) begin
                        right_d     = sample;
                        pair_full_d = 1'b1;
                        state_d     = EXPECT_L;
                    end else begin
                        left_d     = sample;
                        sync_err_d = 1'b1;
                    end
                end
                default: state_d = EXPECT_L;
            endcase
        end

        tready_d = !pair_full_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            left_q      <= '0;
            right_q     <= '0;
            state_q     <= EXPECT_L;
            pair_full_q <= 1'b0;
            tready_q    <= 1'b0;
            sdata_q     <= 1'b0;
            shift_q     <= '0;
            underrun_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            left_q      <= left_d;
            right_q     <= right_d;
            state_q     <= state_d;
            pair_full_q <= pair_full_d;
            tready_q    <= tready_d;
            sdata_q     <= sdata_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign I2S_SDATA     = sdata_q;
    assign underrun      = underrun_q;
    assign sync_err      = sync_err_q;

endmodule
